cam_px_capture: RTL and testbench
=================================

# cam_px_capture

Parametrised camera-to-framebuffer capture engine: samples the two-byte-per-pixel stream from the OV7670-class sensor (D, HREF, VSYNC on PCLK), converts each pixel to a DW-bit packed RGB word and issues single-cycle writes into the frame buffer. It replaces the fixed RGB444→RGB111 QQVGA writer. It adds an RGB565 input mode, configurable colour depth and frame geometry, explicit frame arming/completion handshakes, per-line byte re-alignment and line-length error detection.

## Interface
- AW, 15: frame-buffer address width; must satisfy 2^AW ≥ H_PIX*V_LINES.
- DW, 3: output pixel width; multiple of 3; BPC = DW/3 bits per channel (1..4), packed {R,G,B}, R in MSBs.
- H_PIX, 160: stored pixels per line.
- V_LINES, 120: stored lines per frame.
- FMT, 0: input format. 0 = RGB444 (byte0 xxxxRRRR, byte1 GGGGBBBB). 1 = RGB565 (byte0 RRRRRGGG, byte1 GGGBBBBB).
- PCLK  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- D  in  8  sensor data byte.
- VSYNC  in  1  frame sync; high = vertical blanking.
- HREF  in  1  line valid; high = data bytes valid.
- capture_en  in  1  level; high arms continuous capture.
- mem_px_addr  out  AW  write address (row*H_PIX + col).
- mem_px_data  out  DW  packed pixel.
- px_wr  out  1  write strobe, one cycle per stored pixel.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- busy  out  1  high from frame start to frame end.
- line_err  out  1  sticky for current frame: some line had a wrong pixel count.

## Operation
- Reset: all outputs 0, state IDLE, byte phase 0, counters 0.
- States:
  - IDLE: leaves to WAIT_VS when capture_en=1.
  - WAIT_VS: waits for a VSYNC falling edge (registered vsync_q=1, VSYNC=0), then enters CAPTURE, busy=1, row=col=0, line_err cleared.
  - CAPTURE: runs until a VSYNC rising edge, then FRAME_END.
  - FRAME_END: one cycle with frame_done=1 and busy=0. Next state is WAIT_VS if capture_en=1, else IDLE.
- Arming while VSYNC is already low does not start a partial frame; capture begins at the next falling edge.
- Dropping capture_en mid-frame does not abort; the current frame completes.
- Byte phase resets to 0 on every HREF rising edge. An odd trailing byte is discarded.
- Channel conversion keeps the top BPC bits of each channel:
  - FMT=0: R = byte0[3:0], G = byte1[7:4], B = byte1[3:0].
  - FMT=1: R = byte0[7:3], G = {byte0[2:0], byte1[7:5]}, B = byte1[4:0].
- Addressing: col increments per stored pixel. On HREF falling edge, row increments and col clears.
- Pixels with col ≥ H_PIX or row ≥ V_LINES are dropped (no px_wr). Addresses never wrap.
- line_err: set on an HREF falling edge when the received pixel count ≠ expected count. Lines after row V_LINES-1 are ignored. Cleared only at the next frame start.
- Reset asserted mid-frame: immediate return to reset values; no frame_done is issued.

## Timing
- D is sampled on PCLK rising edges with HREF=1 and state CAPTURE.
- The edge that samples byte1 also registers mem_px_addr, mem_px_data and px_wr=1. px_wr is high for exactly one cycle.
- Minimum write spacing: 2 PCLK cycles. Latency from byte1 to write: one edge.
- mem_px_addr and mem_px_data hold between writes.
- frame_done is high the cycle after the VSYNC-rise edge is detected.
- A VSYNC rise coincident with HREF=1 ends the frame; the in-flight byte is discarded.

## Configuration
- CAP_DECIM_EN defined: 2:1 decimation in both axes. Only even input columns and even input lines are stored. Expected input per line is 2*H_PIX pixels, and line_err compares against 2*H_PIX. Stored geometry remains H_PIX×V_LINES.
- CAP_DECIM_EN undefined: every input pixel and line is stored 1:1; expected line length is H_PIX.

## Test plan
- Reset/idle: rst low then high, capture_en=0, full frame driven → all outputs stay 0, no px_wr.
- FMT=0, DW=3, H_PIX=4, V_LINES=2, byte pairs 0x0F/0x80 → data 3'b110; 8 writes at addresses 0..7; one frame_done; line_err=0.
- FMT=1, DW=12, byte pair 0xF8/0x1F → data 12'hF0F (R=F, G=0, B=F).
- Misalignment: 3-byte line followed by a normal line → first line yields 1 pixel and line_err=1; next line starts at address H_PIX with correct data.
- Overrun: 6 lines of 6 pixels with H_PIX=4, V_LINES=2 → exactly 8 writes, maximum address 7, line_err=1.
- capture_en deasserted mid-frame → frame completes, frame_done pulses, FSM goes to IDLE, next frame ignored. With CAP_DECIM_EN, an 8×4 input yields 4×2 stored pixels.

Source files
------------

// File: rtl/cam_px_capture.sv
// cam_px_capture: OV7670 byte-pair stream to packed-RGB frame-buffer writes; CAP_DECIM_EN enables 2:1 decimation.
// Latency: one PCLK edge from byte1 to px_wr. No backpressure: the sensor stream cannot be stalled.
module cam_px_capture #(
  parameter int AW      = 15,
  parameter int DW      = 3,
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int FMT     = 0
) (
  input  logic          PCLK,
  input  logic          rst,
  input  logic [7:0]    D,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic          capture_en,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          busy,
  output logic          line_err
);

  localparam int BPC = DW / 3;
`ifdef CAP_DECIM_EN
  localparam int DS = 1;
`else
  localparam int DS = 0;
`endif
  localparam int EXP_PIX   = H_PIX << DS;
  localparam int EXP_LINES = V_LINES << DS;
  // Counters saturate one past the expected size so long lines stay distinguishable.
  localparam int CW = $clog2(EXP_PIX + 2);
  localparam int RW = $clog2(EXP_LINES + 2);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, FRAME_END} state_t;
  state_t state, state_nxt;

  logic          vsync_q, href_q, phase;
  logic [7:0]    byte0;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic          vs_fall, vs_rise, href_rise;
  logic          in_range, keep;
  logic [AW-1:0] st_row, st_col, px_addr;
  logic [DW-1:0] px_conv;
  logic          unused_bits;

  assign vs_fall   = vsync_q & ~VSYNC;
  assign vs_rise   = ~vsync_q & VSYNC;
  assign href_rise = HREF & ~href_q;
  assign unused_bits = ^{byte0, D};

  generate
    if (FMT == 1) begin : g_565
      logic [4:0] r5, b5;
      logic [5:0] g6;
      assign r5 = byte0[7:3];
      assign g6 = {byte0[2:0], D[7:5]};
      assign b5 = D[4:0];
      assign px_conv = {r5[4 -: BPC], g6[5 -: BPC], b5[4 -: BPC]};
    end else begin : g_444
      assign px_conv = {byte0[3 -: BPC], D[7 -: BPC], D[3 -: BPC]};
    end
  endgenerate

  assign in_range = (in_col < CW'(EXP_PIX)) && (in_row < RW'(EXP_LINES));
  assign keep     = in_range && ((DS == 0) || (!in_col[0] && !in_row[0]));
  assign st_col   = AW'(in_col >> DS);
  assign st_row   = AW'(in_row >> DS);
  assign px_addr  = st_row * AW'(H_PIX) + st_col;

  always_ff @(posedge PCLK or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:      if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS:   if (vs_fall) state_nxt = CAPTURE;
      CAPTURE: begin
        busy = 1'b1;
        if (vs_rise) state_nxt = FRAME_END;
      end
      FRAME_END: begin
        frame_done = 1'b1;
        state_nxt  = capture_en ? WAIT_VS : IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      byte0       <= '0;
      in_col      <= '0;
      in_row      <= '0;
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      line_err    <= 1'b0;
    end else begin
      vsync_q <= VSYNC;
      href_q  <= HREF;
      px_wr   <= 1'b0;
      if (state == WAIT_VS && vs_fall) begin
        in_col   <= '0;
        in_row   <= '0;
        phase    <= 1'b0;
        line_err <= 1'b0;
      end else if (state == CAPTURE && !vs_rise) begin
        if (HREF) begin
          if (href_rise || !phase) begin
            byte0 <= D;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (keep) begin
              px_wr       <= 1'b1;
              mem_px_addr <= px_addr;
              mem_px_data <= px_conv;
            end
            if (in_col != CW'(EXP_PIX + 1)) in_col <= in_col + 1'b1;
          end
        end else if (href_q) begin
          // End of line: an odd trailing byte is dropped by clearing the phase.
          if (in_row < RW'(EXP_LINES) && in_col != CW'(EXP_PIX)) line_err <= 1'b1;
          in_col <= '0;
          phase  <= 1'b0;
          if (in_row != RW'(EXP_LINES + 1)) in_row <= in_row + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_px_capture.sv
// Scoreboard bench: two instances (RGB444/3-bit and RGB565/12-bit) share one sensor stream.
module tb_cam_px_capture;
  localparam int AW = 4;
  localparam int H  = 4;
  localparam int V  = 2;
`ifdef CAP_DECIM_EN
  localparam int DS = 1;
`else
  localparam int DS = 0;
`endif

  logic        PCLK = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  D = 8'h00;
  logic        VSYNC = 1'b1;
  logic        HREF = 1'b0;
  logic        capture_en = 1'b0;

  logic [AW-1:0] a_addr, b_addr;
  logic [2:0]    a_data;
  logic [11:0]   b_data;
  logic          a_wr, a_done, a_busy, a_err;
  logic          b_wr, b_done, b_busy, b_err;

  cam_px_capture #(.AW(AW), .DW(3), .H_PIX(H), .V_LINES(V), .FMT(0)) dut_a (
    .PCLK(PCLK), .rst(rst), .D(D), .VSYNC(VSYNC), .HREF(HREF), .capture_en(capture_en),
    .mem_px_addr(a_addr), .mem_px_data(a_data), .px_wr(a_wr),
    .frame_done(a_done), .busy(a_busy), .line_err(a_err));

  cam_px_capture #(.AW(AW), .DW(12), .H_PIX(H), .V_LINES(V), .FMT(1)) dut_b (
    .PCLK(PCLK), .rst(rst), .D(D), .VSYNC(VSYNC), .HREF(HREF), .capture_en(capture_en),
    .mem_px_addr(b_addr), .mem_px_data(b_data), .px_wr(b_wr),
    .frame_done(b_done), .busy(b_busy), .line_err(b_err));

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [11:0]   d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0, bad = 0;
  int done_a = 0, done_b = 0, busy_a = 0, wr_a = 0, wr_b = 0;
  int exp_done = 0, exp_wr = 0;
  bit exp_err = 0;
  int m_row;
  bit m_cap, m_err;

  // Reference conversion: take the top bpc bits of each channel from the 16-bit sensor word.
  function automatic int conv(input int fmt, input int bpc, input int b0, input int b1);
    int r, g, b;
    if (fmt == 0) begin
      r = (b0 % 16) >> (4 - bpc);
      g = (b1 / 16) >> (4 - bpc);
      b = (b1 % 16) >> (4 - bpc);
    end else begin
      r = (b0 / 8) >> (5 - bpc);
      g = ((b0 % 8) * 8 + b1 / 32) >> (6 - bpc);
      b = (b1 % 32) >> (5 - bpc);
    end
    return (r << (2 * bpc)) | (g << bpc) | b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (rst) begin
        if (a_wr) begin
          wr_a++;
          chk("write a expected", int'(qa.size() > 0), 1);
          if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("addr a", int'(a_addr), int'(e.a));
            chk("data a", int'(a_data), int'(e.d));
          end
        end
        if (b_wr) begin
          wr_b++;
          chk("write b expected", int'(qb.size() > 0), 1);
          if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("addr b", int'(b_addr), int'(e.a));
            chk("data b", int'(b_data), int'(e.d));
          end
        end
        if (a_done) done_a++;
        if (b_done) done_b++;
        if (a_busy) busy_a++;
      end
    end
  end

  task automatic frame_start(input bit cap);
    m_row = 0;
    m_cap = cap;
    m_err = 0;
    VSYNC = 1'b0;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic line(input int nbytes, input bit rnd, input logic [7:0] pa, input logic [7:0] pb);
    logic [7:0] bytes[$];
    int npix;
    for (int i = 0; i < nbytes; i++)
      bytes.push_back(rnd ? 8'($urandom) : ((i % 2 == 0) ? pa : pb));
    npix = nbytes / 2;
    if (m_cap) begin
      for (int p = 0; p < npix; p++) begin
        if (m_row < (V << DS) && p < (H << DS) && (DS == 0 || (p % 2 == 0 && m_row % 2 == 0))) begin
          qa.push_back('{a: AW'((m_row >> DS) * H + (p >> DS)),
                         d: 12'(conv(0, 1, int'(bytes[2*p]), int'(bytes[2*p+1])))});
          qb.push_back('{a: AW'((m_row >> DS) * H + (p >> DS)),
                         d: 12'(conv(1, 4, int'(bytes[2*p]), int'(bytes[2*p+1])))});
          exp_wr++;
        end
      end
    end
    if (m_row < (V << DS) && npix != (H << DS)) m_err = 1;
    m_row++;
    for (int i = 0; i < nbytes; i++) begin
      HREF = 1'b1;
      D = bytes[i];
      @(negedge PCLK);
    end
    HREF = 1'b0;
    D = 8'h00;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic frame_end();
    VSYNC = 1'b1;
    repeat (5) @(negedge PCLK);
    if (m_cap) begin
      exp_done++;
      exp_err = m_err;
    end
  endtask

  task automatic check_frame(input string tag);
    @(posedge PCLK);
    #1;
    chk({tag, " done a"}, done_a, exp_done);
    chk({tag, " done b"}, done_b, exp_done);
    chk({tag, " line_err a"}, int'(a_err), int'(exp_err));
    chk({tag, " line_err b"}, int'(b_err), int'(exp_err));
    chk({tag, " writes a"}, wr_a, exp_wr);
    chk({tag, " writes b"}, wr_b, exp_wr);
    chk({tag, " pending a"}, qa.size(), 0);
    chk({tag, " pending b"}, qb.size(), 0);
    @(negedge PCLK);
  endtask

  initial begin : stim
    int nl;
    repeat (3) @(negedge PCLK);
    chk("reset px_wr", int'(a_wr | b_wr), 0);
    chk("reset frame_done", int'(a_done | b_done), 0);
    chk("reset busy", int'(a_busy | b_busy), 0);
    chk("reset line_err", int'(a_err | b_err), 0);
    chk("reset addr", int'(a_addr | b_addr), 0);
    chk("reset data", int'(b_data) | int'(a_data), 0);
    rst = 1'b1;
    repeat (2) @(negedge PCLK);

    frame_start(0);
    repeat (2) line(8, 0, 8'h0F, 8'h80);
    frame_end();
    check_frame("disarmed");
    chk("busy while disarmed", busy_a, 0);

    capture_en = 1'b1;
    repeat (2) @(negedge PCLK);
    frame_start(1);
    repeat (2) line(8, 0, 8'h0F, 8'h80);
    frame_end();
    check_frame("rgb444");
    chk("busy seen", int'(busy_a > 0), 1);

    frame_start(1);
    repeat (2) line(8, 0, 8'hF8, 8'h1F);
    frame_end();
    check_frame("rgb565");

    frame_start(1);
    line(3, 0, 8'h0F, 8'h80);
    line(8, 0, 8'hF8, 8'h1F);
    frame_end();
    check_frame("misalign");

    frame_start(1);
    repeat (6) line(12, 1, 8'h00, 8'h00);
    frame_end();
    check_frame("overrun");

    for (int f = 0; f < 5; f++) begin
      frame_start(1);
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) line($urandom_range(1, 12), 1, 8'h00, 8'h00);
      frame_end();
      check_frame("random");
    end

    frame_start(1);
    line(8, 1, 8'h00, 8'h00);
    capture_en = 1'b0;
    line(8, 1, 8'h00, 8'h00);
    frame_end();
    check_frame("disarm mid-frame");
    frame_start(0);
    repeat (2) line(8, 1, 8'h00, 8'h00);
    frame_end();
    check_frame("after disarm");

    capture_en = 1'b1;
    repeat (2) @(negedge PCLK);
    frame_start(1);
    line(8, 1, 8'h00, 8'h00);
    rst = 1'b0;
    #1;
    chk("mid reset busy", int'(a_busy | b_busy), 0);
    chk("mid reset px_wr", int'(a_wr | b_wr), 0);
    chk("mid reset addr", int'(a_addr | b_addr), 0);
    exp_err = 0;
    @(negedge PCLK);
    VSYNC = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge PCLK);
    check_frame("post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
